// File: rtl/ram_rr_arbiter_if.sv
// ram_rr_arbiter_if
//   Request/response bundle for the two requesters (A and B) sharing the RAM.
//   Each requester has req/write/address/vin going in, and gnt/rvalid/vout
//   coming back.
//   master modport : requester side (drives req/write/address/vin)
//   slave modport  : arbiter side (drives gnt/rvalid/vout)
interface ram_rr_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              a_req;
  logic              a_write;
  logic [ADDR_W-1:0] a_address;
  logic [DATA_W-1:0] a_vin;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_vout;

  logic              b_req;
  logic              b_write;
  logic [ADDR_W-1:0] b_address;
  logic [DATA_W-1:0] b_vin;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_vout;

  modport master (
    output a_req, a_write, a_address, a_vin,
    input  a_gnt, a_rvalid, a_vout,
    output b_req, b_write, b_address, b_vin,
    input  b_gnt, b_rvalid, b_vout
  );

  modport slave (
    input  a_req, a_write, a_address, a_vin,
    output a_gnt, a_rvalid, a_vout,
    input  b_req, b_write, b_address, b_vin,
    output b_gnt, b_rvalid, b_vout
  );
endinterface

// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter
//   Two-requester round-robin arbiter in front of a single-port RAM whose
//   writes commit on the falling edge and whose reads are captured on the
//   rising edge. The RAM command (address/vin/write) is registered here; read
//   data comes back two cycles after the accept edge, tagged to the port that
//   issued the read.
//
//   Ports
//     clk, rst     : clock, synchronous active-high reset
//     bus (slave)  : A/B request channels with gnt, rvalid and vout
//     mem_address  : to RAM address
//     mem_vin      : to RAM write data
//     mem_write    : to RAM write enable
//     mem_vout     : from RAM read data
//     a_count,
//     b_count      : accepted-transfer counters (only with ARB_STATS_EN)
//
//   Optional build macro: ARB_STATS_EN adds saturating per-port grant counters.
module ram_rr_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  ram_rr_arbiter_if.slave   bus,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_vin,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_vout
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count
`endif
);

  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_vin;
  logic              r_mem_write;
  logic              r_last_b;    // 1 = B won the last transfer
  logic              r_t1_valid;  // read tag, access cycle
  logic              r_t1_port;   // 0 = A, 1 = B
  logic              r_t2_valid;  // read tag, response cycle
  logic              r_t2_port;

  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_xfer;
  logic [1:0]        w_gnt_vec;

  // The port that did not win last time has priority on a tie.
  assign w_a_gnt   = ~rst & bus.a_req & (~bus.b_req | r_last_b);
  assign w_b_gnt   = ~rst & bus.b_req & (~bus.a_req | ~r_last_b);
  assign w_xfer    = w_a_gnt | w_b_gnt;
  assign w_gnt_vec = {w_b_gnt, w_a_gnt};

  assign bus.a_gnt = w_a_gnt;
  assign bus.b_gnt = w_b_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_address <= '0;
      r_mem_vin     <= '0;
      r_mem_write   <= 1'b0;
      r_last_b      <= 1'b1;
      r_t1_valid    <= 1'b0;
      r_t1_port     <= 1'b0;
      r_t2_valid    <= 1'b0;
      r_t2_port     <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_mem_address <= w_b_gnt ? bus.b_address : bus.a_address;
        r_mem_vin     <= w_b_gnt ? bus.b_vin     : bus.a_vin;
        r_mem_write   <= w_b_gnt ? bus.b_write   : bus.a_write;
        r_last_b      <= w_b_gnt;
        r_t1_valid    <= w_b_gnt ? ~bus.b_write  : ~bus.a_write;
        r_t1_port     <= w_b_gnt;
      end else begin
        // Idle: address/data hold, but a stale write must not repeat.
        r_mem_write   <= 1'b0;
        r_t1_valid    <= 1'b0;
      end
      r_t2_valid <= r_t1_valid;
      r_t2_port  <= r_t1_port;
    end
  end

  assign mem_address  = r_mem_address;
  assign mem_vin      = r_mem_vin;
  assign mem_write    = r_mem_write;

  // RAM output is shared; only the tagged port sees rvalid.
  assign bus.a_rvalid = r_t2_valid & ~r_t2_port;
  assign bus.b_rvalid = r_t2_valid &  r_t2_port;
  assign bus.a_vout   = mem_vout;
  assign bus.b_vout   = mem_vout;

`ifdef ARB_STATS_EN
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_count;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_count <= '0;
        end else if (w_gnt_vec[gi] && (r_count != {CNT_W{1'b1}})) begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign a_count = g_cnt[0].r_count;
  assign b_count = g_cnt[1].r_count;
`else
  // Counters are not built; keep the grant vector and CNT_W referenced.
  logic w_unused_stats;
  assign w_unused_stats = (^w_gnt_vec) ^ (CNT_W != 0);
`endif

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb_ram_rr_arbiter
//   Directed bench for ram_rr_arbiter with a behavioural 16x16 RAM that writes
//   on the falling edge and registers read data on the rising edge.
module tb_ram_rr_arbiter;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_vin;
  logic              mem_write;
  logic [DATA_W-1:0] mem_vout;
`ifdef ARB_STATS_EN
  logic [CNT_W-1:0]  a_count;
  logic [CNT_W-1:0]  b_count;
`endif

  int checks = 0;
  int errors = 0;

  ram_rr_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_rr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mem_address (mem_address),
    .mem_vin     (mem_vin),
    .mem_write   (mem_write),
    .mem_vout    (mem_vout)
`ifdef ARB_STATS_EN
    ,
    .a_count     (a_count),
    .b_count     (b_count)
`endif
  );

  always #5 clk = ~clk;

  // RAM model; preload fills every word with 0x0100 + address.
  logic [DATA_W-1:0] ram [16];
  logic preload = 1'b0;
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) ram[i] <= 16'h0100 + 16'(i);
    end else if (mem_write) begin
      ram[mem_address] <= mem_vin;
    end
  end
  always @(posedge clk) mem_vout <= ram[mem_address];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [3:0] aa, input logic [15:0] av,
                       input logic br, input logic bw, input logic [3:0] ba, input logic [15:0] bv);
    bus.a_req = ar; bus.a_write = aw; bus.a_address = aa; bus.a_vin = av;
    bus.b_req = br; bus.b_write = bw; bus.b_address = ba; bus.b_vin = bv;
  endtask

  initial begin
    logic exp_a;
    logic [15:0] exp_d;

    // 1. Reset with both requesting
    rst = 1'b1;
    drive(1, 0, 4'd0, 16'h0, 1, 0, 4'd0, 16'h0);
    #1;
    chk("rst_a_gnt", 32'(bus.a_gnt), 32'd0);
    chk("rst_b_gnt", 32'(bus.b_gnt), 32'd0);
    preload = 1'b1;
    tick();
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", 32'(mem_address), 32'd0);
    chk("rst_rvalids", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd0);
    tick();
    preload = 1'b0;
    chk("rst_a_gnt2", 32'(bus.a_gnt), 32'd0);
    rst = 1'b0;
    drive(0, 0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0);
    tick();

    // 2. A writes BEEF @3, then reads it back
    drive(1, 1, 4'd3, 16'hBEEF, 0, 0, 4'd0, 16'h0);
    #1;
    chk("s2_wr_gnt", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd2);
    tick();
    chk("s2_mem_cmd", {11'd0, mem_write, mem_address, mem_vin}, {11'd0, 1'b1, 4'd3, 16'hBEEF});
    drive(1, 0, 4'd3, 16'h0, 0, 0, 4'd0, 16'h0);
    #1;
    chk("s2_rd_gnt", 32'(bus.a_gnt), 32'd1);
    tick();
    drive(0, 0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0);
    chk("s2_rv_early", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd0);
    tick();
    chk("s2_rvalid", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd2);
    chk("s2_vout", 32'(bus.a_vout), 32'hBEEF);
    tick();
    chk("s2_rv_once", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd0);

    // Reset pulse so the pointer is back to "B last"
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // 3. Contention: A reads @1, B reads @2, 10 grants, strict alternation
    for (int i = 0; i < 12; i++) begin
      if (i >= 2) begin
        exp_a = ((i - 2) % 2 == 0);
        exp_d = exp_a ? 16'h0101 : 16'h0102;
        chk("s3_rvalid", {30'd0, bus.a_rvalid, bus.b_rvalid}, {30'd0, exp_a, ~exp_a});
        chk("s3_vout", 32'(exp_a ? bus.a_vout : bus.b_vout), 32'(exp_d));
      end else begin
        chk("s3_rv_idle", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd0);
      end
      if (i < 10) begin
        drive(1, 0, 4'd1, 16'h0, 1, 0, 4'd2, 16'h0);
        #1;
        chk("s3_gnt", {30'd0, bus.a_gnt, bus.b_gnt}, (i % 2 == 0) ? 32'd2 : 32'd1);
      end else begin
        drive(0, 0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0);
      end
      tick();
    end
`ifdef ARB_STATS_EN
    chk("s3_a_count", 32'(a_count), 32'd5);
    chk("s3_b_count", 32'(b_count), 32'd5);
`endif

    // 4. RAW: B writes 1234 @5, A reads @5 on the next edge
    drive(0, 0, 4'd0, 16'h0, 1, 1, 4'd5, 16'h1234);
    #1;
    chk("s4_b_gnt", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd1);
    tick();
    drive(1, 0, 4'd5, 16'h0, 0, 0, 4'd0, 16'h0);
    #1;
    chk("s4_a_gnt", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd2);
    tick();
    drive(0, 0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0);
    chk("s4_no_wr_rv", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd0);
    tick();
    chk("s4_rvalid", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd2);
    chk("s4_raw_vout", 32'(bus.a_vout), 32'h1234);
    tick();
    tick();

    // 5. B alone, 6 back-to-back reads of freshly preloaded 0..5
    preload = 1'b1;
    @(negedge clk);
    #1;
    preload = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      if (i >= 2 && i < 8) begin
        chk("s5_rvalid", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd1);
        chk("s5_vout", 32'(bus.b_vout), 32'h0100 + 32'(i - 2));
      end else begin
        chk("s5_rv_idle", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd0);
      end
      if (i < 6) begin
        drive(0, 0, 4'd0, 16'h0, 1, 0, 4'(i), 16'h0);
        #1;
        chk("s5_b_gnt", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd1);
      end else begin
        drive(0, 0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0);
      end
      tick();
    end

    // 6. Read accepted, then reset on the next edge: no response
    drive(1, 0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0);
    #1;
    chk("s6_a_gnt", 32'(bus.a_gnt), 32'd1);
    tick();
    drive(0, 0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_no_rv1", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd0);
    tick();
    chk("s6_no_rv2", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd0);
`ifdef ARB_STATS_EN
    chk("s6_cnt_clr", {a_count, b_count}, 32'd0);
`endif

    // Write presented during reset is discarded and never commits
    rst = 1'b1;
    drive(1, 1, 4'd7, 16'hDEAD, 0, 0, 4'd0, 16'h0);
    #1;
    chk("s6_rst_gnt", 32'(bus.a_gnt), 32'd0);
    tick();
    chk("s6_rst_mwr", 32'(mem_write), 32'd0);
    rst = 1'b0;
    drive(0, 0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0);
    tick();
    tick();
    chk("s6_ram7", 32'(ram[7]), 32'h0107);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
Two-requester round-robin arbiter that shares one 16x16 single-port RAM (the memory_design block) between requesters A and B. It drives the RAM `address`/`vin`/`write` inputs from registers and returns read data to the winning requester with a tagged one-cycle valid. It sits between two independent masters (e.g. a control FSM and a host/UART path) and the RAM instance.

Parameters:
- DATA_W, 16, data width; must match RAM word width.
- ADDR_W, 4, address width; RAM depth is 2**ADDR_W.
- CNT_W, 16, width of optional grant counters.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- a_req  in  1  A requests an access; held until a_gnt.
- a_write  in  1  1 = write, 0 = read.
- a_address  in  ADDR_W  A word address.
- a_vin  in  DATA_W  A write data.
- a_gnt  out  1  A access accepted this cycle (combinational).
- a_rvalid  out  1  A read data valid (one cycle).
- a_vout  out  DATA_W  A read data; meaningful only with a_rvalid.
- b_req, b_write, b_address, b_vin, b_gnt, b_rvalid, b_vout: same as A for requester B.
- mem_address  out  ADDR_W  to RAM `address`.
- mem_vin  out  DATA_W  to RAM `vin`.
- mem_write  out  1  to RAM `write`.
- mem_vout  in  DATA_W  from RAM `vout`.

Behaviour:
- Decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: mem_address=0, mem_vin=0, mem_write=0, a_rvalid=b_rvalid=0, pipeline tags cleared, last-winner pointer=B, so A wins the first tie.
- Grant (combinational), forced 0 while rst=1:
  - a_gnt = a_req & (~b_req | last==B).
  - b_gnt = b_req & (~a_req | last==A).
  - At most one grant per cycle.
  - Single requester gets a grant every cycle, with no bubbles.
- Transfer occurs on the rising edge where req&gnt=1, at edge T:
  - mem_address, mem_vin and mem_write are loaded from the winner's address, data and write fields.
  - last <= winner.
  - Stage-1 tag <= {valid = ~write, port}.
- No transfer at edge T: mem_write <= 0; mem_address and mem_vin hold.
- Access cycle T+1: RAM sees the registered command.
  - A write commits at the falling edge inside T+1.
  - A read is captured by RAM at the rising edge ending T+1.
- Read response in cycle T+2:
  - The tagged port's rvalid=1 for exactly one cycle.
  - x_vout = mem_vout, combinational pass-through to both a_vout and b_vout.
  - The other port's rvalid stays 0.
  - Read latency is 2 cycles after the accept edge. Throughput is 1 access/cycle, pipelined.
- mem_vout changes on write cycles too; it is ignored unless a stage-2 tag is valid.
- Read-after-write, same address, back-to-back grants: the read returns the newly written data, because the write commits at the negedge before the read's capture edge.
- Write-after-read, same address, back-to-back: the read returns the old data.
- Simultaneous requests under continuous contention: grants strictly alternate.
- Requester dropping req before gnt: no transfer, no pointer change.
- Reset mid-operation:
  - A transfer on an edge with rst=1 is discarded.
  - In-flight read tags are cleared, so no rvalid is emitted for them.
  - mem_write=0 after the reset edge, so a write registered at that edge never commits.
- Address arithmetic: none; addresses pass through unmodified, with no wrap logic.

Optional Feature:
- ARB_STATS_EN defined:
  - Adds outputs a_count and b_count (CNT_W each).
  - Each counter increments on every accepted transfer of its port.
  - Counters saturate at all-ones and reset to 0 on rst.
- Not defined: the count ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold rst 2 cycles with a_req=b_req=1 -> a_gnt=b_gnt=0; mem_write=0, mem_address=0, rvalids=0 after the edge.
2. A writes 0xBEEF @3, then A reads @3 -> a_rvalid=1 exactly 2 cycles after the read accept with a_vout=0xBEEF; b_rvalid stays 0.
3. a_req and b_req held high, reads @1 and @2 for 8 cycles -> grants A,B,A,B,...; responses tagged accordingly.
4. B writes 0x1234 @5 on edge T, A reads @5 accepted on edge T+1 -> a_vout=0x1234 at T+3 (RAW coherence).
5. B alone, 6 back-to-back reads of addresses 0..5 (preloaded with 0x0100+addr) -> b_gnt every cycle; b_rvalid for 6 consecutive cycles returning 0x0100..0x0105 in order.
6. A read accepted at T, rst=1 at T+1 -> no a_rvalid. With ARB_STATS_EN, scenario 3 run for 10 grants gives a_count=5, b_count=5; with CNT_W=2 the count stops at 3.
